// File: rtl/multi_row_buffer_pkg.sv
// multi_row_buffer_pkg: shared sizing helper for the multi-row line buffer.
package multi_row_buffer_pkg;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/multi_row_buffer_if.sv
// multi_row_buffer_if: pixel-in / column-out bundle for the multi-row line buffer.
interface multi_row_buffer_if import multi_row_buffer_pkg::*; #(
  parameter int DATA_WIDTH = 26,
  parameter int LINE_WIDTH = 640,
  parameter int NUM_ROWS   = 3
) ();
  localparam int COL_W = clog2(LINE_WIDTH);
  logic                           in_valid;
  logic                           sop;
  logic [COL_W:0]                 line_len;
  logic [DATA_WIDTH-1:0]          data_in;
  logic                           out_valid;
  logic [NUM_ROWS*DATA_WIDTH-1:0] data_out;
  logic [COL_W-1:0]               out_col;
  logic                           out_eol;
  modport master (
    output in_valid, sop, line_len, data_in,
    input  out_valid, data_out, out_col, out_eol
  );
  modport slave (
    input  in_valid, sop, line_len, data_in,
    output out_valid, data_out, out_col, out_eol
  );
endinterface

// File: rtl/multi_row_buffer_line_delay_ram.sv
// multi_row_buffer_line_delay_ram: one line of delay, read-before-write, registered read plus
// same-cycle cascade tap feeding the next line memory.
module multi_row_buffer_line_delay_ram #(
  parameter int DATA_WIDTH = 26,
  parameter int DEPTH      = 640,
  parameter int AW         = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [AW-1:0]         addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-1:0] cas_data
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_q, rd_d;
  assign cas_data = mem[addr];
  assign rd_data  = rd_q;
  always_comb rd_d = en ? cas_data : rd_q;
  always_ff @(posedge clk) if (en) mem[addr] <= wr_data;
  always_ff @(posedge clk) begin
    if (rst) rd_q <= '0;
    else     rd_q <= rd_d;
  end
endmodule

// File: rtl/multi_row_buffer.sv
// multi_row_buffer: NUM_ROWS-tall column line buffer with runtime line length and row-fill gating.
// Define MULTI_ROW_BUFFER_BORDER_REPLICATE_EN to emit from the first row with top-border replication.
module multi_row_buffer import multi_row_buffer_pkg::*; #(
  parameter int DATA_WIDTH = 26,
  parameter int LINE_WIDTH = 640,
  parameter int NUM_ROWS   = 3
) (
  input logic               clk,
  input logic               rst,
  multi_row_buffer_if.slave bus
);
  localparam int COL_W = clog2(LINE_WIDTH);
  localparam int ROW_W = clog2(NUM_ROWS);
  localparam int LW    = COL_W + 1;
  localparam int NM    = NUM_ROWS - 1;
  logic                  acc, wrap;
  logic [COL_W-1:0]      col_q, col_d, col_cur, ocol_q, ocol_d;
  logic [LW-1:0]         len_q, len_d, len_cur, len_in;
  logic [ROW_W-1:0]      fill_q, fill_d, fill_cur, fill_o_q, fill_o_d;
  logic                  vld_q, vld_d, eol_q, eol_d;
  logic [DATA_WIDTH-1:0] pix_q, pix_d;
  logic [DATA_WIDTH-1:0] wr   [NUM_ROWS];
  logic [DATA_WIDTH-1:0] lane [NUM_ROWS];
  assign acc     = bus.in_valid & ~rst;
  assign wr[0]   = bus.data_in;
  assign lane[0] = pix_q;
  // sop restarts the frame in the same cycle, so the current pixel already sees column 0 / row 0
  always_comb begin
    len_in   = (bus.line_len == '0 || bus.line_len > LW'(LINE_WIDTH)) ? LW'(LINE_WIDTH) : bus.line_len;
    col_cur  = bus.sop ? '0 : col_q;
    fill_cur = bus.sop ? '0 : fill_q;
    len_cur  = bus.sop ? len_in : len_q;
    wrap     = LW'(col_cur) == len_cur - LW'(1);
    col_d    = !acc ? col_q : wrap ? '0 : col_cur + COL_W'(1);
    fill_d   = !acc ? fill_q : (wrap && fill_cur != ROW_W'(NM)) ? fill_cur + ROW_W'(1) : fill_cur;
    len_d    = !acc ? len_q : wrap ? len_in : len_cur;
    vld_d    = acc;
    fill_o_d = acc ? fill_cur : fill_o_q;
    ocol_d   = acc ? col_cur : ocol_q;
    eol_d    = acc ? wrap : eol_q;
    pix_d    = acc ? bus.data_in : pix_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q    <= '0;
      len_q    <= LW'(LINE_WIDTH);
      fill_q   <= '0;
      fill_o_q <= '0;
      vld_q    <= 1'b0;
      ocol_q   <= '0;
      eol_q    <= 1'b0;
      pix_q    <= '0;
    end else begin
      col_q    <= col_d;
      len_q    <= len_d;
      fill_q   <= fill_d;
      fill_o_q <= fill_o_d;
      vld_q    <= vld_d;
      ocol_q   <= ocol_d;
      eol_q    <= eol_d;
      pix_q    <= pix_d;
    end
  end
  for (genvar j = 0; j < NM; j++) begin : g_ram
    multi_row_buffer_line_delay_ram #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (LINE_WIDTH),
      .AW        (COL_W)
    ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .en      (acc),
      .addr    (col_cur),
      .wr_data (wr[j]),
      .rd_data (lane[j+1]),
      .cas_data(wr[j+1])
    );
  end
  assign bus.out_col = ocol_q;
  assign bus.out_eol = eol_q;
`ifdef MULTI_ROW_BUFFER_BORDER_REPLICATE_EN
  assign bus.out_valid = vld_q;
  for (genvar k = 0; k < NUM_ROWS; k++) begin : g_lane
    assign bus.data_out[k*DATA_WIDTH +: DATA_WIDTH] = (ROW_W'(k) > fill_o_q) ? lane[fill_o_q] : lane[k];
  end
`else
  assign bus.out_valid = vld_q && (fill_o_q == ROW_W'(NM));
  for (genvar k = 0; k < NUM_ROWS; k++) begin : g_lane
    assign bus.data_out[k*DATA_WIDTH +: DATA_WIDTH] = lane[k];
  end
`endif
endmodule

// File: tb/tb_multi_row_buffer.sv
// tb_multi_row_buffer: directed and randomized checks of multi_row_buffer against an image-coordinate model.
module tb_multi_row_buffer;
  localparam int DW = 26;
  localparam int LW = 8;
  localparam int NR = 3;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  multi_row_buffer_if #(.DATA_WIDTH(DW), .LINE_WIDTH(LW), .NUM_ROWS(NR)) bus ();
  multi_row_buffer #(.DATA_WIDTH(DW), .LINE_WIDTH(LW), .NUM_ROWS(NR)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  int errors = 0;
  int checks = 0;
  int m_col, m_row, m_len;
  logic [DW-1:0]    img [NR][LW];
  logic             exp_valid, exp_eol;
  logic [2:0]       exp_col;
  logic [NR*DW-1:0] exp_data, hold_data;
  bit               hold_known;
  string            phase;

  function automatic int eff(input int l);
    return (l == 0 || l > LW) ? LW : l;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s/%s: got %0h expected %0h", phase, tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_col = 0;
    m_row = 0;
    m_len = LW;
    hold_known = 1;
    hold_data = '0;
  endtask

  // pixel (row r, col c) of the frame; lane k shows row r-k at column c
  task automatic accept(input logic [DW-1:0] d, input logic s);
    int rk;
    if (s) begin
      m_col = 0;
      m_row = 0;
      m_len = eff(int'(bus.line_len));
    end
    img[m_row % NR][m_col] = d;
`ifdef MULTI_ROW_BUFFER_BORDER_REPLICATE_EN
    exp_valid = 1'b1;
`else
    exp_valid = m_row >= NR - 1;
`endif
    for (int k = 0; k < NR; k++) begin
      rk = m_row - k;
      if (rk < 0) rk = 0;
      exp_data[k*DW +: DW] = img[rk % NR][m_col];
    end
    exp_col = 3'(m_col);
    exp_eol = m_col == m_len - 1;
    if (exp_eol) begin
      m_col = 0;
      m_row++;
      m_len = eff(int'(bus.line_len));
    end else m_col++;
    hold_known = exp_valid;
    hold_data = exp_data;
  endtask

  task automatic step(input logic v, input logic s, input logic [DW-1:0] d);
    bus.in_valid = v;
    bus.sop = s;
    bus.data_in = d;
    if (v) accept(d, s);
    @(posedge clk);
    #1;
    if (v) begin
      check("valid", 128'(bus.out_valid), 128'(exp_valid));
      if (exp_valid) begin
        check("data", 128'(bus.data_out), 128'(exp_data));
        check("col", 128'(bus.out_col), 128'(exp_col));
        check("eol", 128'(bus.out_eol), 128'(exp_eol));
      end
    end else begin
      check("stall_valid", 128'(bus.out_valid), 128'(0));
      if (hold_known) check("stall_hold", 128'(bus.data_out), 128'(hold_data));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.sop = 1'b1;
    @(posedge clk);
    #1;
    check("rst_valid", 128'(bus.out_valid), 128'(0));
    check("rst_data", 128'(bus.data_out), 128'(0));
    check("rst_col", 128'(bus.out_col), 128'(0));
    check("rst_eol", 128'(bus.out_eol), 128'(0));
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.sop = 1'b0;
    model_reset();
  endtask

  initial begin
    logic v, s;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.sop = 1'b0;
    bus.line_len = 4'd8;
    bus.data_in = '0;
    model_reset();
    @(posedge clk);
    #1;
    phase = "reset";
    do_reset();
    phase = "t1";
    for (int i = 0; i < 32; i++) begin
      step(1'b1, i == 0, DW'(i));
`ifdef MULTI_ROW_BUFFER_BORDER_REPLICATE_EN
      if (i == 0) check("in0", 128'(bus.data_out), 128'({26'd0, 26'd0, 26'd0}));
      if (i == 8) check("in8", 128'(bus.data_out), 128'({26'd0, 26'd0, 26'd8}));
`else
      if (i == 15) check("in15_gated", 128'(bus.out_valid), 128'(0));
`endif
      if (i == 16) check("in16", 128'({bus.out_valid, bus.out_col, bus.data_out}), 128'({1'b1, 3'd0, 26'd0, 26'd8, 26'd16}));
      if (i == 23) check("in23", 128'({bus.out_eol, bus.data_out}), 128'({1'b1, 26'd7, 26'd15, 26'd23}));
    end
    phase = "t2";
    for (int i = 32; i < 36; i++) step(1'b1, 1'b0, DW'(i));
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0);
    for (int i = 36; i < 48; i++) begin
      step(1'b1, 1'b0, DW'(i));
      if (i == 36) check("resume_col", 128'(bus.out_col), 128'(4));
    end
    phase = "t3";
    bus.line_len = 4'd5;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, i == 0, DW'(i));
      if (i == 10) check("len5_in10", 128'({bus.out_col, bus.data_out}), 128'({3'd0, 26'd0, 26'd5, 26'd10}));
      if (i == 14) check("len5_eol", 128'({bus.out_eol, bus.out_col}), 128'({1'b1, 3'd4}));
    end
    bus.line_len = 4'd0;
    for (int i = 0; i < 24; i++) begin
      step(1'b1, i == 0, DW'(i));
      if (i == 16) check("len0_in16", 128'(bus.data_out), 128'({26'd0, 26'd8, 26'd16}));
    end
    phase = "t4";
    bus.line_len = 4'd8;
    for (int i = 0; i < 27; i++) step(1'b1, i == 0, DW'(i));
    for (int j = 0; j < 24; j++) begin
      step(1'b1, j == 0, DW'(1000 + j));
      if (j == 16) check("restart_in16", 128'(bus.data_out), 128'({26'd1000, 26'd1008, 26'd1016}));
    end
    phase = "t5";
    for (int i = 0; i < 20; i++) step(1'b1, i == 0, DW'(i));
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0, DW'(500 + i));
`ifndef MULTI_ROW_BUFFER_BORDER_REPLICATE_EN
      if (i == 15) check("post_rst_gated", 128'(bus.out_valid), 128'(0));
`endif
      if (i == 16) check("post_rst_in16", 128'(bus.data_out), 128'({26'd500, 26'd508, 26'd516}));
    end
    phase = "rand";
    for (int i = 0; i < 800; i++) begin
      v = $urandom_range(0, 9) < 8;
      s = v && ($urandom_range(0, 49) == 0);
      if (s) bus.line_len = 4'($urandom_range(0, 10));
      step(v, s, DW'($urandom));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
